// File: rtl/prime_check_scheduler_pkg.sv
// Shared types and constants for the prime-check scheduler and its remainder unit.
package prime_check_scheduler_pkg;

  localparam int W     = 16;
  localparam int N_OPS = 4;
  localparam int KMAX  = 255;
  localparam int K_W   = $clog2(KMAX + 1);
  localparam int IDX_W = $clog2(N_OPS);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD      = 4'd1,
    S_SCREEN    = 4'd2,
    S_DIV_ISSUE = 4'd3,
    S_DIV_WAIT  = 4'd4,
    S_STEP      = 4'd5,
    S_RECORD    = 4'd6,
    S_NEXT_OP   = 4'd7,
    S_FINISH    = 4'd8
  } state_e;

endpackage

// File: rtl/prime_check_scheduler_rem_unit.sv
// Restoring divider that returns only the remainder of dividend / divisor.
// The first quotient bit is resolved on the loading edge, so div_valid arrives 16 cycles after div_start.
module rem_unit
  import prime_check_scheduler_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           div_start,
  input  logic [W-1:0]   dividend,
  input  logic [K_W-1:0] divisor,
  output logic [K_W-1:0] rem,
  output logic           div_valid
);

  logic [K_W-1:0] r_rem;
  logic [W-1:0]   r_dvd;
  logic [K_W-1:0] r_dsr;
  logic [3:0]     r_cnt;
  logic           r_run;
  logic           r_valid;

  // Partial remainder is always below the divisor, so it fits in K_W bits.
  function automatic logic [K_W-1:0] rem_step(input logic [K_W-1:0] r, input logic b,
                                              input logic [K_W-1:0] dsr);
    logic [K_W:0] t;
    t = {r, b};
    if (t >= {1'b0, dsr}) t = t - {1'b0, dsr};
    return t[K_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dsr   <= '0;
      r_cnt   <= '0;
      r_run   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (div_start) begin
        r_rem <= rem_step('0, dividend[W-1], divisor);
        r_dvd <= {dividend[W-2:0], 1'b0};
        r_dsr <= divisor;
        r_cnt <= 4'd15;
        r_run <= 1'b1;
      end else if (r_run) begin
        r_rem <= rem_step(r_rem, r_dvd[W-1], r_dsr);
        r_dvd <= {r_dvd[W-2:0], 1'b0};
        r_cnt <= r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          r_run   <= 1'b0;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign rem       = r_rem;
  assign div_valid = r_valid;

endmodule

// File: rtl/prime_check_scheduler.sv
// Classifies operands a..d as prime by trial division on one shared remainder unit.
// Valid/ready: rem_unit takes div_start as a one-cycle pulse; its result is valid only in the div_valid cycle and held after.
module prime_check_scheduler
  import prime_check_scheduler_pkg::*;
(
  input  logic         CLOCK_50,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [W-1:0] g,
  output logic [W-1:0] h,
  output logic         done,
  output logic         busy,
  output state_e       o_dbg_state
);

  state_e           r_state;
  logic [W-1:0]     r_op [N_OPS];
  logic [IDX_W-1:0] r_idx;
  logic [K_W-1:0]   r_k;
  logic [W:0]       r_sq;
  logic             r_prime;
  logic [N_OPS-1:0] r_g;
  logic [W-1:0]     r_h;
  logic             r_done;
  logic             r_busy;
  logic             r_div_start;

  logic [W-1:0]     w_n;
  logic [K_W-1:0]   w_rem;
  logic             w_div_valid;
  logic [W:0]       w_sq_next;

  assign w_n = r_op[r_idx];
  // (k+1)^2 = k^2 + 2k + 1, tracked incrementally instead of multiplying.
  assign w_sq_next = r_sq + {{(W-K_W){1'b0}}, r_k, 1'b0} + {{W{1'b0}}, 1'b1};

  rem_unit u_rem (
    .clk       (CLOCK_50),
    .rst       (rst),
    .div_start (r_div_start),
    .dividend  (w_n),
    .divisor   (r_k),
    .rem       (w_rem),
    .div_valid (w_div_valid)
  );

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      for (int i = 0; i < N_OPS; i++) r_op[i] <= '0;
      r_idx       <= '0;
      r_k         <= '0;
      r_sq        <= '0;
      r_prime     <= 1'b0;
      r_g         <= '0;
      r_h         <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_div_start <= 1'b0;
    end else begin
      r_div_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !r_done) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_op[0] <= a;
          r_op[1] <= b;
          r_op[2] <= c;
          r_op[3] <= d;
          r_idx   <= '0;
          r_g     <= '0;
          r_h     <= '0;
          r_busy  <= 1'b1;
          r_state <= S_SCREEN;
        end
        S_SCREEN: begin
          if (w_n < W'(2)) begin
            r_prime <= 1'b0;
            r_state <= S_RECORD;
          end else if (w_n < W'(4)) begin
            r_prime <= 1'b1;
            r_state <= S_RECORD;
          end else begin
            r_k         <= K_W'(2);
            r_sq        <= (W+1)'(4);
            r_div_start <= 1'b1;
            r_state     <= S_DIV_ISSUE;
          end
        end
        S_DIV_ISSUE: r_state <= S_DIV_WAIT;
        S_DIV_WAIT: begin
          if (w_div_valid) r_state <= S_STEP;
        end
        S_STEP: begin
          if (w_rem == '0) begin
            r_prime <= 1'b0;
            r_state <= S_RECORD;
          end else if (w_sq_next > {1'b0, w_n}) begin
            r_prime <= 1'b1;
            r_state <= S_RECORD;
          end else begin
            r_sq        <= w_sq_next;
            r_k         <= r_k + K_W'(1);
            r_div_start <= 1'b1;
            r_state     <= S_DIV_ISSUE;
          end
        end
        S_RECORD: begin
          r_g[r_idx] <= r_prime;
          if (r_prime && (w_n > r_h)) r_h <= w_n;
          r_state <= S_NEXT_OP;
        end
        S_NEXT_OP: begin
          r_idx   <= r_idx + IDX_W'(1);
          r_state <= (r_idx == IDX_W'(N_OPS - 1)) ? S_FINISH : S_SCREEN;
        end
        S_FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign g           = {{(W-N_OPS){1'b0}}, r_g};
  assign h           = r_h;
  assign done        = r_done;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_prime_check_scheduler.sv
// Directed bench for prime_check_scheduler and its rem_unit, checked against a trial-division model.
module tb_prime_check_scheduler;
  import prime_check_scheduler_pkg::*;

  logic         CLOCK_50;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b, c, d;
  logic [W-1:0] g, h;
  logic         done, busy;
  state_e       dbg_state;

  logic           rd_start;
  logic [W-1:0]   rd_dvd;
  logic [K_W-1:0] rd_dsr;
  logic [K_W-1:0] rd_rem;
  logic           rd_valid;

  int d_tests = 0, d_fail = 0;
  int m_tests = 0, m_fail = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_g, cur_h;
  bit           have_exp;
  logic         prev_done;

  prime_check_scheduler dut (
    .CLOCK_50    (CLOCK_50),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .g           (g),
    .h           (h),
    .done        (done),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  rem_unit u_rem_tb (
    .clk       (CLOCK_50),
    .rst       (rst),
    .div_start (rd_start),
    .dividend  (rd_dvd),
    .divisor   (rd_dsr),
    .rem       (rd_rem),
    .div_valid (rd_valid)
  );

  // clock / reset
  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #1800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int i = 2; i * i <= n; i++)
      if (n % i == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk_drv(input string name, input logic [31:0] act, input logic [31:0] exp);
    d_tests++;
    if (act !== exp) begin
      d_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int oa, input int ob, input int oc, input int od);
    int ops[4];
    logic [W-1:0] eg, eh;
    ops[0] = oa; ops[1] = ob; ops[2] = oc; ops[3] = od;
    eg = '0;
    eh = '0;
    for (int i = 0; i < 4; i++) begin
      if (is_prime(ops[i])) begin
        eg[i] = 1'b1;
        if (ops[i] > int'(eh)) eh = W'(ops[i]);
      end
    end
    exp_q.push_back(eg);
    exp_q.push_back(eh);
  endtask

  // scoreboard: on each done rise pull the expected g/h, then hold them while done stays high
  always @(negedge CLOCK_50) begin
    if (!rst) begin
      have_exp = 1'b0;
    end else begin
      if (done && !prev_done) begin
        m_tests++;
        if (exp_q.size() < 2) begin
          m_fail++;
          $display("FAIL sb_empty: done rose with %0d queued, expected 2", exp_q.size());
        end else begin
          cur_g = exp_q.pop_front();
          cur_h = exp_q.pop_front();
          have_exp = 1'b1;
        end
      end
      if (done && have_exp) begin
        m_tests++;
        if (g !== cur_g) begin
          m_fail++;
          $display("FAIL sb_g: got %0h expected %0h", g, cur_g);
        end
        m_tests++;
        if (h !== cur_h) begin
          m_fail++;
          $display("FAIL sb_h: got %0d expected %0d", h, cur_h);
        end
      end
    end
    prev_done = done;
  end

  // driver tasks
  task automatic do_reset();
    rst = 1'b0;
    start = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge CLOCK_50);
    #1 rst = 1'b1;
  endtask

  task automatic set_ops(input int oa, input int ob, input int oc, input int od);
    a = W'(oa); b = W'(ob); c = W'(oc); d = W'(od);
  endtask

  task automatic wait_done(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge CLOCK_50); #1;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk_drv(name, 32'(got), 32'd1);
  endtask

  task automatic run_ops(input string name, input int oa, input int ob, input int oc, input int od);
    set_ops(oa, ob, oc, od);
    push_exp(oa, ob, oc, od);
    start = 1'b1;
    wait_done(name);
    @(posedge CLOCK_50); #1;
  endtask

  task automatic rem_test(input int dvd, input int dsr, input int exp_rem);
    int cnt;
    @(posedge CLOCK_50); #1;
    rd_dvd = W'(dvd);
    rd_dsr = K_W'(dsr);
    rd_start = 1'b1;
    @(posedge CLOCK_50); #1;
    rd_start = 1'b0;
    cnt = 1;
    while (!rd_valid && cnt < 40) begin
      @(posedge CLOCK_50); #1;
      cnt++;
    end
    chk_drv("rem_latency", 32'(cnt), 32'd16);
    chk_drv("rem_value", 32'(rd_rem), 32'(exp_rem));
    @(posedge CLOCK_50); #1;
    chk_drv("rem_pulse", 32'(rd_valid), 32'd0);
  endtask

  initial begin
    int errs;
    rst = 1'b0; start = 1'b0; rd_start = 1'b0; rd_dvd = '0; rd_dsr = '0;
    prev_done = 1'b0;
    set_ops(0, 0, 0, 0);
    do_reset();

    // model pins
    chk_drv("model_65521", 32'(is_prime(65521)), 32'd1);
    chk_drv("model_65535", 32'(is_prime(65535)), 32'd0);
    chk_drv("model_1", 32'(is_prime(1)), 32'd0);
    chk_drv("model_2", 32'(is_prime(2)), 32'd1);

    // reset state and idle without start
    chk_drv("rst_g", 32'(g), 32'd0);
    chk_drv("rst_h", 32'(h), 32'd0);
    chk_drv("rst_done", 32'(done), 32'd0);
    chk_drv("rst_busy", 32'(busy), 32'd0);
    errs = 0;
    repeat (20) begin
      @(posedge CLOCK_50); #1;
      if (busy !== 1'b0 || dbg_state !== S_IDLE) errs++;
    end
    chk_drv("idle_no_start", 32'(errs), 32'd0);

    // standalone remainder unit
    rem_test(1000, 7, 6);
    rem_test(65535, 255, 0);
    rem_test(65521, 255, 65521 % 255);
    rem_test(12345, 3, 12345 % 3);

    // 1
    run_ops("t1_done", 2, 9, 1, 13);
    chk_drv("t1_g", 32'(g), 32'h0009);
    chk_drv("t1_h", 32'(h), 32'd13);

    // 2
    do_reset();
    run_ops("t2_done", 65521, 65535, 0, 4);
    chk_drv("t2_g", 32'(g), 32'h0001);
    chk_drv("t2_h", 32'(h), 32'd65521);

    // 3
    do_reset();
    run_ops("t3a_done", 4, 4, 4, 4);
    chk_drv("t3a_g", 32'(g), 32'h0000);
    chk_drv("t3a_h", 32'(h), 32'd0);
    do_reset();
    run_ops("t3b_done", 3, 3, 3, 3);
    chk_drv("t3b_g", 32'(g), 32'h000F);
    chk_drv("t3b_h", 32'(h), 32'd3);

    // 4: reset during DIV_WAIT, then rerun with start held high
    do_reset();
    set_ops(65521, 2, 8, 17);
    push_exp(65521, 2, 8, 17);
    start = 1'b1;
    repeat (60) @(posedge CLOCK_50);
    #1;
    errs = 1;
    for (int i = 0; i < 40; i++) begin
      if (dbg_state == S_DIV_WAIT) begin
        errs = 0;
        break;
      end
      @(posedge CLOCK_50); #1;
    end
    chk_drv("t4_reach_wait", 32'(errs), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    @(negedge CLOCK_50);
    chk_drv("t4_rst_g", 32'(g), 32'd0);
    chk_drv("t4_rst_h", 32'(h), 32'd0);
    chk_drv("t4_rst_done", 32'(done), 32'd0);
    chk_drv("t4_rst_busy", 32'(busy), 32'd0);
    push_exp(65521, 2, 8, 17);
    @(posedge CLOCK_50); #1;
    rst = 1'b1;
    wait_done("t4_done");
    chk_drv("t4_g", 32'(g), 32'h000B);
    chk_drv("t4_h", 32'(h), 32'd65521);

    // 5: inputs change after LOAD, start held after done
    do_reset();
    set_ops(7, 10, 11, 121);
    push_exp(7, 10, 11, 121);
    start = 1'b1;
    repeat (4) @(posedge CLOCK_50);
    #1;
    chk_drv("t5_busy", 32'(busy), 32'd1);
    set_ops(2, 3, 5, 7);
    wait_done("t5_done");
    chk_drv("t5_g", 32'(g), 32'h0005);
    chk_drv("t5_h", 32'(h), 32'd11);
    errs = 0;
    repeat (100) begin
      @(posedge CLOCK_50); #1;
      if (done !== 1'b1 || busy !== 1'b0 || dbg_state !== S_IDLE) errs++;
    end
    chk_drv("t5_sticky", 32'(errs), 32'd0);
    chk_drv("t5_g_held", 32'(g), 32'h0005);
    start = 1'b0;

    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    $display("[TB] %0d tests run, %0d failed", d_tests + m_tests, d_fail + m_fail);
    $finish;
  end

endmodule
